// File: rtl/sram_master_pkg.sv
// Shared encodings for the SRAM initiator: access sizes, FSM states and the
// alignment rule that decides whether a request touches the SRAM at all.
package sram_master_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RD_WAIT,
        WRITE,
        RSP
    } state_e;

    // Reserved size or a half/word access not aligned to its own width.
    function automatic logic access_error(input size_e size, input logic [1:0] addr_lo);
        case (size)
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            SZ_RSVD: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sram_master_if.sv
// Request, response and SRAM-side signals of the initiator. The master modport
// is the initiator's view; the slave modport is the CPU stage plus SRAM.
interface sram_master_if #(
    parameter int SRAM_AW = 14,
    parameter int DATA_W  = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic               sram_en;
    logic [3:0]         sram_wen;
    logic [SRAM_AW-1:0] sram_addr;
    logic [DATA_W-1:0]  sram_wdata;
    logic [DATA_W-1:0]  sram_rdata;

    modport master (
        input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata,
        input  rsp_ready, sram_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output sram_en, sram_wen, sram_addr, sram_wdata
    );

    modport slave (
        output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata,
        output rsp_ready, sram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  sram_en, sram_wen, sram_addr, sram_wdata
    );

endinterface

// File: rtl/sram_lane_align.sv
// Little-endian lane handling: extracts and extends load data from a read word,
// and merges partial store data into a read word for read-modify-write.
module sram_lane_align
    import sram_master_pkg::*;
(
    input  size_e       size,
    input  logic        is_signed,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [4:0]  shift;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign shift    = {addr_lo, 3'b000};
    assign byte_val = rdata[shift +: 8];
    assign half_val = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data = rdata;
        case (size)
            SZ_BYTE: load_data = {{24{is_signed & byte_val[7]}}, byte_val};
            SZ_HALF: load_data = {{16{is_signed & half_val[15]}}, half_val};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        merged_word = rdata;
        case (size)
            SZ_BYTE: merged_word[shift +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (addr_lo[1])
                    merged_word[31:16] = wdata[15:0];
                else
                    merged_word[15:0] = wdata[15:0];
            end
            default: merged_word = wdata;
        endcase
    end

endmodule

// File: rtl/sram_master.sv
// Single-outstanding load/store initiator for the word-wide SRAM responder.
// Partial stores are read-modify-write because the responder writes whole words.
module sram_master
    import sram_master_pkg::*;
#(
    parameter int SRAM_AW = 14,
    parameter int DATA_W  = 32
) (
    input  logic          clk,
    input  logic          reset,
    sram_master_if.master bus
);

    state_e             state;
    state_e             next_state;
    logic               wr_q;
    logic               signed_q;
    size_e              size_q;
    logic [SRAM_AW-1:0] addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               err_q;

    logic               req_err;
    logic [31:0]        load_data;
    logic [31:0]        merged_word;
    logic               unused_addr_bits;

    assign req_err          = access_error(size_e'(bus.req_size), bus.req_addr[1:0]);
    assign unused_addr_bits = ^bus.req_addr[31:SRAM_AW];

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    sram_lane_align u_align (
        .size        (size_q),
        .is_signed   (signed_q),
        .addr_lo     (addr_q[1:0]),
        .rdata       (bus.sram_rdata),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state     = state;
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.sram_en    = 1'b0;
        bus.sram_wen   = 4'h0;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (req_err)
                        next_state = RSP;
                    else if (bus.req_wr && size_e'(bus.req_size) == SZ_WORD)
                        next_state = WRITE;
                    else
                        next_state = READ;
                end
            end
            READ: begin
                bus.sram_en   = 1'b1;
                bus.sram_addr = {addr_q[SRAM_AW-1:2], 2'b00};
                next_state    = RD_WAIT;
            end
            RD_WAIT: begin
                next_state = wr_q ? WRITE : RSP;
            end
            WRITE: begin
                bus.sram_en    = 1'b1;
                bus.sram_wen   = 4'hF;
                bus.sram_addr  = {addr_q[SRAM_AW-1:2], 2'b00};
                bus.sram_wdata = wdata_q;
                next_state     = RSP;
            end
            RSP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // Reset masks the SRAM strobes at once so an in-flight write never lands.
        if (reset) begin
            bus.req_ready  = 1'b0;
            bus.rsp_valid  = 1'b0;
            bus.sram_en    = 1'b0;
            bus.sram_wen   = 4'h0;
            bus.sram_addr  = '0;
            bus.sram_wdata = '0;
        end
    end

    // wdata_q carries the store word and is overwritten by the merged word for RMW.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= SZ_BYTE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        wr_q     <= bus.req_wr;
                        signed_q <= bus.req_signed;
                        size_q   <= size_e'(bus.req_size);
                        addr_q   <= bus.req_addr[SRAM_AW-1:0];
                        wdata_q  <= bus.req_wdata;
                        rdata_q  <= '0;
                        err_q    <= req_err;
                    end
                end
                RD_WAIT: begin
                    if (wr_q)
                        wdata_q <= merged_word;
                    else
                        rdata_q <= load_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_master.sv
// Self-checking bench for sram_master: directed vector table, backpressure and
// mid-write reset sequences, then random traffic against a byte-level memory model.
module tb_sram_master;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_reads;
        int          exp_writes;
    } vec_t;

    logic clk;
    logic reset;

    sram_master_if #(.SRAM_AW(14), .DATA_W(32)) bus ();

    sram_master #(.SRAM_AW(14), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;

    logic [31:0] mem [0:4095];
    int          total_reads  = 0;
    int          total_writes = 0;
    int          bad_wen      = 0;
    logic [13:0] last_rd_addr = '0;
    logic [13:0] last_wr_addr = '0;

    logic [7:0]  ref_mem [0:16383];
    vec_t        vecs [24];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM responder: read data appears the cycle after en.
    always @(posedge clk) begin
        if (bus.sram_wen != 4'h0 && bus.sram_wen != 4'hF)
            bad_wen <= bad_wen + 1;
        if (bus.sram_en) begin
            if (bus.sram_wen != 4'h0) begin
                mem[bus.sram_addr[13:2]] <= bus.sram_wdata;
                total_writes <= total_writes + 1;
                last_wr_addr <= bus.sram_addr;
            end else begin
                bus.sram_rdata <= mem[bus.sram_addr[13:2]];
                total_reads    <= total_reads + 1;
                last_rd_addr   <= bus.sram_addr;
            end
        end
    end

    task automatic checkOutput(input string tag, input string name,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s %s: got 0x%08h expected 0x%08h", tag, name, actual, expected);
        else
            passes++;
    endtask

    function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int lat, input int rd, input int wrc);
        vec_t v;
        v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = lat;
        v.exp_reads = rd; v.exp_writes = wrc;
        return v;
    endfunction

    // Issue one request, wait for the response, optionally stall it, then release.
    task automatic applyStimulus(input string tag, input vec_t v, input int hold);
        int lat;
        int guard;
        int rd0;
        int wr0;
        @(negedge clk);
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput(tag, "req_ready", 32'(bus.req_ready), 32'd1);
        rd0 = total_reads;
        wr0 = total_writes;
        bus.req_valid  = 1'b1;
        bus.req_wr     = v.wr;
        bus.req_size   = v.size;
        bus.req_signed = v.sgn;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput(tag, "latency", 32'(lat), 32'(v.exp_lat));
        checkOutput(tag, "rsp_rdata", bus.rsp_rdata, v.exp_rdata);
        checkOutput(tag, "rsp_err", 32'(bus.rsp_err), 32'(v.exp_err));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput(tag, "hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput(tag, "hold_rsp_rdata", bus.rsp_rdata, v.exp_rdata);
            checkOutput(tag, "hold_req_ready", 32'(bus.req_ready), 32'd0);
            checkOutput(tag, "hold_sram_en", 32'(bus.sram_en), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checkOutput(tag, "idle_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput(tag, "idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput(tag, "sram_reads", 32'(total_reads - rd0), 32'(v.exp_reads));
        checkOutput(tag, "sram_writes", 32'(total_writes - wr0), 32'(v.exp_writes));
        if (v.exp_reads > 0)
            checkOutput(tag, "rd_addr", {18'd0, last_rd_addr}, v.addr & 32'h3FFC);
        if (v.exp_writes > 0)
            checkOutput(tag, "wr_addr", {18'd0, last_wr_addr}, v.addr & 32'h3FFC);
    endtask

    function automatic logic ref_err(input logic [1:0] size, input logic [31:0] a);
        return (size == 2'd3) || (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn,
                                             input logic [31:0] a);
        int n;
        logic [31:0] v;
        n = 1 << size;
        v = 32'd0;
        for (int i = 0; i < n; i++)
            v = v | (32'(ref_mem[(a & 32'h3FFF) + 32'(i)]) << (8 * i));
        if (sgn && n < 4 && v[8*n-1])
            v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 1 << size;
        for (int i = 0; i < n; i++)
            ref_mem[(a & 32'h3FFF) + 32'(i)] = 8'(d >> (8 * i));
    endtask

    task automatic random_op(input string tag, input logic wr, input logic [1:0] size,
                             input logic sgn, input logic [31:0] a, input logic [31:0] d);
        vec_t v;
        logic err;
        err = ref_err(size, a);
        v = mk(wr, size, sgn, a, d,
               (!wr && !err) ? ref_load(size, sgn, a) : 32'd0, err,
               err ? 1 : (wr ? (size == 2'd2 ? 2 : 4) : 3),
               (err || (wr && size == 2'd2)) ? 0 : 1,
               (err || !wr) ? 0 : 1);
        applyStimulus(tag, v, 0);
        if (wr && !err)
            ref_store(size, a, d);
    endtask

    initial begin
        vec_t v;
        int guard;
        int wr0;

        vecs[0]  = mk(1, 2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1);
        vecs[1]  = mk(0, 2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 1, 0);
        vecs[2]  = mk(1, 2, 0, 32'h20, 32'h11223344, 32'h0, 0, 2, 0, 1);
        vecs[3]  = mk(0, 0, 1, 32'h23, 32'h0, 32'h00000011, 0, 3, 1, 0);
        vecs[4]  = mk(1, 0, 0, 32'h21, 32'hFFFFFF80, 32'h0, 0, 4, 1, 1);
        vecs[5]  = mk(0, 0, 1, 32'h21, 32'h0, 32'hFFFFFF80, 0, 3, 1, 0);
        vecs[6]  = mk(0, 0, 0, 32'h21, 32'h0, 32'h00000080, 0, 3, 1, 0);
        vecs[7]  = mk(0, 2, 0, 32'h20, 32'h0, 32'h11228044, 0, 3, 1, 0);
        vecs[8]  = mk(1, 2, 0, 32'h30, 32'hAAAAAAAA, 32'h0, 0, 2, 0, 1);
        vecs[9]  = mk(1, 1, 0, 32'h32, 32'h1234BEEF, 32'h0, 0, 4, 1, 1);
        vecs[10] = mk(0, 2, 0, 32'h30, 32'h0, 32'hBEEFAAAA, 0, 3, 1, 0);
        vecs[11] = mk(0, 1, 1, 32'h32, 32'h0, 32'hFFFFBEEF, 0, 3, 1, 0);
        vecs[12] = mk(0, 1, 0, 32'h32, 32'h0, 32'h0000BEEF, 0, 3, 1, 0);
        vecs[13] = mk(0, 1, 1, 32'h30, 32'h0, 32'hFFFFAAAA, 0, 3, 1, 0);
        vecs[14] = mk(0, 1, 0, 32'h05, 32'h0, 32'h0, 1, 1, 0, 0);
        vecs[15] = mk(0, 2, 0, 32'h06, 32'h0, 32'h0, 1, 1, 0, 0);
        vecs[16] = mk(0, 3, 0, 32'h00, 32'h0, 32'h0, 1, 1, 0, 0);
        vecs[17] = mk(1, 3, 0, 32'h40, 32'h12345678, 32'h0, 1, 1, 0, 0);
        vecs[18] = mk(1, 1, 0, 32'h07, 32'h0000FFFF, 32'h0, 1, 1, 0, 0);
        vecs[19] = mk(0, 0, 1, 32'h20, 32'h0, 32'h00000044, 0, 3, 1, 0);
        vecs[20] = mk(0, 2, 0, 32'hABCD0010, 32'h0, 32'hDEADBEEF, 0, 3, 1, 0);
        vecs[21] = mk(1, 0, 0, 32'h33, 32'h0000007F, 32'h0, 0, 4, 1, 1);
        vecs[22] = mk(0, 2, 0, 32'h30, 32'h0, 32'h7FEFAAAA, 0, 3, 1, 0);
        vecs[23] = mk(0, 0, 1, 32'h31, 32'h0, 32'hFFFFFFAA, 0, 3, 1, 0);

        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_size = 2'd0;
        bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset", "req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("reset", "rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset", "rsp_rdata", bus.rsp_rdata, 32'd0);
        checkOutput("reset", "rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("reset", "sram_en", 32'(bus.sram_en), 32'd0);
        checkOutput("reset", "sram_wen", 32'(bus.sram_wen), 32'd0);
        checkOutput("reset", "sram_addr", 32'(bus.sram_addr), 32'd0);
        checkOutput("reset", "sram_wdata", bus.sram_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset", "ready_after_release", 32'(bus.req_ready), 32'd1);

        $display("[TB] directed vector table");
        for (int i = 0; i < 24; i++)
            applyStimulus($sformatf("vec%0d", i), vecs[i], 0);

        $display("[TB] response backpressure");
        applyStimulus("stall", mk(0, 2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 1, 0), 5);

        $display("[TB] reset during read-modify-write");
        @(negedge clk);
        wr0 = total_writes;
        bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_size = 2'd0;
        bus.req_signed = 1'b0; bus.req_addr = 32'h22; bus.req_wdata = 32'h55;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (bus.sram_wen != 4'hF && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("rst_mid", "write_reached", 32'(bus.sram_wen), 32'hF);
        reset = 1'b1;
        #1;
        checkOutput("rst_mid", "sram_en_masked", 32'(bus.sram_en), 32'd0);
        checkOutput("rst_mid", "sram_wen_masked", 32'(bus.sram_wen), 32'd0);
        @(negedge clk);
        checkOutput("rst_mid", "req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rst_mid", "rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_mid", "rsp_rdata", bus.rsp_rdata, 32'd0);
        checkOutput("rst_mid", "rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("rst_mid", "sram_addr", 32'(bus.sram_addr), 32'd0);
        checkOutput("rst_mid", "sram_wdata", bus.sram_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid", "no_write", 32'(total_writes - wr0), 32'd0);
        checkOutput("rst_mid", "mem_word", mem[8], 32'h11228044);
        applyStimulus("rst_mid_load", mk(0, 2, 0, 32'h20, 32'h0, 32'h11228044, 0, 3, 1, 0), 0);

        $display("[TB] random traffic against memory model");
        for (int i = 0; i < 16; i++)
            random_op($sformatf("init%0d", i), 1'b1, 2'd2, 1'b0, 32'h100 + 32'(4 * i), $urandom);
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_C000) | (32'h100 + 32'($urandom_range(0, 63)));
            random_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
        end

        checkOutput("final", "wen_encoding", 32'(bad_wen), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
